// File: rtl/alu_mc_if.sv
// Issue/result bundle between the core's EXECUTE stage (master) and alu_mc (slave).
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic                    enable;
    logic                    start;
    logic                    cmp_mode;
    logic [2:0]              op;
    logic signed [WIDTH-1:0] rs;
    logic signed [WIDTH-1:0] rt;
    logic                    busy;
    logic                    done;
    logic signed [WIDTH-1:0] result;
    logic                    div_by_zero;

    modport master (
        output enable, start, cmp_mode, op, rs, rt,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  enable, start, cmp_mode, op, rs, rt,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle execute ALU: one-cycle arithmetic/compare plus a WIDTH-iteration restoring signed divider.
// Define ALU_MC_SATURATE_EN to clamp ADD/SUB/FIXED_MUL/DIV signed overflow instead of wrapping.
module alu_mc #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 24
) (
    input  logic    clk,
    input  logic    reset,
    alu_mc_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_FMUL = 3'd3;
    localparam logic [2:0] OP_SLL  = 3'd4;
    localparam logic [2:0] OP_SRL  = 3'd5;
    localparam logic [2:0] OP_SRA  = 3'd6;
    localparam logic [2:0] OP_DIV  = 3'd7;
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
`ifdef ALU_MC_SATURATE_EN
    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic {IDLE = 1'b0, DIV_RUN = 1'b1} state_t;

`ifdef ALU_MC_SATURATE_EN
    function automatic logic [WIDTH-1:0] add_res(input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b,
                                                 input logic sub);
        logic signed [WIDTH-1:0] s;
        logic                    ovf;
        s   = sub ? a - b : a + b;
        // Overflow needs like signs for ADD, unlike signs for SUB, and a flipped result sign.
        ovf = ((a[WIDTH-1] ^ b[WIDTH-1]) == sub) && (s[WIDTH-1] != a[WIDTH-1]);
        return ovf ? (a[WIDTH-1] ? S_MIN : S_MAX) : s;
    endfunction

    function automatic logic [WIDTH-1:0] fixed_res(input logic signed [2*WIDTH-1:0] p);
        logic signed [2*WIDTH-1:0] sh;
        sh = p >>> FRAC_BITS;
        if (!(&sh[2*WIDTH-1:WIDTH-1]) && (|sh[2*WIDTH-1:WIDTH-1]))
            return sh[2*WIDTH-1] ? S_MIN : S_MAX;
        return sh[WIDTH-1:0];
    endfunction
`else
    function automatic logic [WIDTH-1:0] add_res(input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b,
                                                 input logic sub);
        return sub ? a - b : a + b;
    endfunction

    function automatic logic [WIDTH-1:0] fixed_res(input logic signed [2*WIDTH-1:0] p);
        return WIDTH'(p >>> FRAC_BITS);
    endfunction
`endif

    function automatic logic [WIDTH-1:0] div_res(input logic [WIDTH-1:0] q,
                                                 input logic neg, input logic dz);
        if (dz)
            return '1;
`ifdef ALU_MC_SATURATE_EN
        // Only most-negative / -1 yields a positive magnitude with the top bit set.
        if (!neg && q[WIDTH-1])
            return S_MAX;
`endif
        return neg ? ~q + ONE : q;
    endfunction

    state_t                  state_q, state_d;
    logic [SHW-1:0]          cnt_q, cnt_d;
    logic [WIDTH-1:0]        rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic                    neg_q, neg_d, zero_q, zero_d;
    logic [WIDTH-1:0]        result_q, result_d;
    logic                    done_q, done_d, dz_q, dz_d;

    logic signed [2*WIDTH-1:0] prod;
    logic [SHW-1:0]            shamt;
    logic [WIDTH-1:0]          alu_res, quo_nx, rem_nx;
    logic [WIDTH:0]            rem_sh, diff;

    always_comb begin
        prod    = (2*WIDTH)'(bus.rs) * (2*WIDTH)'(bus.rt);
        shamt   = bus.rt[SHW-1:0];
        alu_res = '0;
        if (bus.cmp_mode) begin
            alu_res = {{(WIDTH-3){1'b0}}, bus.rs > bus.rt, bus.rs == bus.rt, bus.rs < bus.rt};
        end else begin
            case (bus.op)
                OP_ADD:  alu_res = add_res(bus.rs, bus.rt, 1'b0);
                OP_SUB:  alu_res = add_res(bus.rs, bus.rt, 1'b1);
                OP_MUL:  alu_res = prod[WIDTH-1:0];
                OP_FMUL: alu_res = fixed_res(prod);
                OP_SLL:  alu_res = bus.rs << shamt;
                OP_SRL:  alu_res = bus.rs >> shamt;
                OP_SRA:  alu_res = bus.rs >>> shamt;
                default: alu_res = '0;
            endcase
        end
    end

    // One restoring shift-subtract step on the latched magnitudes.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        quo_nx = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        rem_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        neg_d    = neg_q;
        zero_d   = zero_q;
        result_d = result_q;
        dz_d     = dz_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (bus.start) begin
                if (bus.op == OP_DIV && !bus.cmp_mode) begin
                    state_d = DIV_RUN;
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = bus.rs[WIDTH-1] ? ~bus.rs + ONE : bus.rs;
                    dvs_d   = bus.rt[WIDTH-1] ? ~bus.rt + ONE : bus.rt;
                    neg_d   = bus.rs[WIDTH-1] ^ bus.rt[WIDTH-1];
                    zero_d  = (bus.rt == '0);
                end else begin
                    result_d = alu_res;
                    dz_d     = 1'b0;
                    done_d   = 1'b1;
                end
            end
        end else begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == SHW'(WIDTH - 1)) begin
                state_d  = IDLE;
                result_d = div_res(quo_nx, neg_q, zero_q);
                dz_d     = zero_q;
                done_d   = 1'b1;
            end
        end
    end

    // enable low freezes every register, so a pending done waits for the next enabled cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            neg_q    <= 1'b0;
            zero_q   <= 1'b0;
            result_q <= '0;
            dz_q     <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.enable) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            neg_q    <= neg_d;
            zero_q   <= zero_d;
            result_q <= result_d;
            dz_q     <= dz_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy        = (state_q == DIV_RUN);
    assign bus.done        = done_q & bus.enable;
    assign bus.result      = result_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the core's single-cycle execute ALU.
- Adds:
  - a start/busy/done handshake
  - configurable data width and fixed-point format
  - an iterative signed divider, so the synthesised combinational divide is gone
  - a divide-by-zero flag
- Sits in each core's EXECUTE stage. The core scheduler holds EXECUTE until done pulses.

Parameters:
- WIDTH, 32, operand/result width in bits. Valid range 8..64.
- FRAC_BITS, 24, fraction bits for FIXED_MUL. Valid range 0..WIDTH-1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- enable  in  1  core enable; low freezes all state, including the divider mid-run
- start  in  1  issue strobe; sampled only when enable=1 and busy=0
- cmp_mode  in  1  1 = comparison, 0 = arithmetic
- op  in  3  0 ADD, 1 SUB, 2 MUL, 3 FIXED_MUL, 4 SLL, 5 SRL, 6 SRA, 7 DIV
- rs  in  WIDTH  signed operand A
- rt  in  WIDTH  signed operand B
- busy  out  1  divider running
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  result register; holds until next completion
- div_by_zero  out  1  registered with result; set only by DIV with rt==0

Behaviour:
- Reset values: result=0, done=0, busy=0, div_by_zero=0, FSM=IDLE, internal counter/partials=0.
- Reset mid-divide aborts it: no done pulse, result=0.
- FSM states: IDLE, DIV_RUN.
- Accepted start in IDLE with a non-DIV op, or with cmp_mode=1:
  - result/done registered on the same edge; done=1 in the next cycle (latency 1)
  - FSM stays IDLE; busy stays 0
  - back-to-back starts every cycle are legal
- Accepted start with op=DIV and cmp_mode=0:
  - latch |rs|, |rt| and the two sign bits
  - FSM goes to DIV_RUN, busy=1
  - counter runs WIDTH iterations of restoring shift-subtract, one per enabled cycle
  - at the final iteration: FSM returns to IDLE, busy=0, result written, done=1 the next cycle
  - latency is exactly WIDTH+1 enabled cycles from the start cycle to the done cycle
- start while busy=1 is ignored. No queueing, no error.
- enable=0:
  - no state changes; done is forced to 0 for that cycle
  - a done pulse that would have fired is deferred to the first enabled cycle
- Arithmetic rules (WIDTH-bit, two's complement):
  - ADD/SUB: wrap modulo 2^WIDTH
  - MUL: low WIDTH bits of the 2*WIDTH signed product
  - FIXED_MUL: product bits [FRAC_BITS+WIDTH-1 : FRAC_BITS], truncation (floor)
  - SLL/SRL/SRA: shift amount = rt[$clog2(WIDTH)-1:0]; SRA sign-fills
  - DIV: signed quotient truncated toward zero; quotient negated iff the operand signs differ
- DIV corner cases:
  - rt==0: still takes the full WIDTH+1 latency; result = all ones; div_by_zero=1
  - rs=most-negative, rt=-1: result = most-negative (wrap); div_by_zero=0
- div_by_zero is cleared by every other completion.
- Comparison (cmp_mode=1), signed: result = {zeros, GT, EQ, LT} in bits [2:0]; exactly one bit is set.
- done and busy are never 1 in the same cycle.

Optional Feature:
- Macro: ALU_MC_SATURATE_EN.
- Defined: ADD, SUB and FIXED_MUL clamp to the most-positive or most-negative WIDTH-bit value on signed overflow, instead of wrapping. MUL, shifts and DIV are unchanged; the DIV most-negative/-1 case also saturates to most-positive.
- Undefined: all ops wrap as specified above; no extra logic is present.

Test Plan:
- WIDTH=32, ADD rs=0x7FFFFFFF, rt=1 -> done next cycle, result=0x80000000 (wrap); with ALU_MC_SATURATE_EN, result=0x7FFFFFFF.
- FIXED_MUL rs=0x01800000 (1.5), rt=0xFF000000 (-1.0), FRAC_BITS=24 -> result=0xFE800000 (-1.5), latency 1.
- DIV rs=-7, rt=2 -> busy high 32 cycles, done in cycle 33 after start, result=-3, div_by_zero=0; a start pulsed during busy is ignored.
- DIV rs=5, rt=0 -> result=0xFFFFFFFF, div_by_zero=1 at done; a following ADD 1+1 -> result=2, div_by_zero=0.
- cmp_mode=1, rs=-1, rt=1 -> result=0x00000001 (LT); rs=rt=9 -> 0x00000002 (EQ).
- DIV started, enable low for 5 cycles mid-run -> done arrives exactly 5 cycles late; reset at iteration 10 -> busy=0, done never pulses, result=0.
